// File: rtl/bus_decoder.sv
// Single-master address decoder and transaction sequencer for the SoC slaves.
// Optional slave response timeout is enabled by defining BUS_TIMEOUT_EN.
module bus_decoder #(
    parameter logic [31:0] rom_base       = 32'h0,
    parameter logic [31:0] rom_top        = 32'h80,
    parameter logic [31:0] uart_base      = 32'h1000000,
    parameter logic [31:0] uart_top       = 32'h1000004,
    parameter logic [31:0] clint_base     = 32'h2000000,
    parameter logic [31:0] clint_top      = 32'h200C000,
    parameter logic [31:0] tim0_base      = 32'h10000000,
    parameter logic [31:0] tim0_top       = 32'h10100000,
    parameter logic [31:0] tim1_base      = 32'h20000000,
    parameter logic [31:0] tim1_top       = 32'h20100000,
    parameter logic [31:0] ram_base       = 32'h80000000,
    parameter logic [31:0] ram_top        = 32'h90000000,
    parameter int          timeout_cycles = 1024
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         m_valid,
    input  logic         m_instr,
    input  logic [31:0]  m_addr,
    input  logic [31:0]  m_wdata,
    input  logic [3:0]   m_wstrb,
    output logic [31:0]  m_rdata,
    output logic         m_ready,
    output logic         m_error,
    output logic [5:0]   s_valid,
    output logic         s_instr,
    output logic [31:0]  s_addr,
    output logic [31:0]  s_wdata,
    output logic [3:0]   s_wstrb,
    input  logic [191:0] s_rdata,
    input  logic [5:0]   s_ready
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_sel;
    logic [31:0] r_rdata;
    logic        r_error;
    logic [5:0]  w_hit;
    logic [2:0]  w_hitIdx;
    logic        w_accept;
    logic        w_capture;
    logic        w_selReady;
    logic [31:0] w_selData;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(timeout_cycles + 1);
    logic [CNT_W-1:0] r_count;
    logic             w_timeout;
`endif

    // Windows are [base, top); scanning downward lets the lowest index win on overlap.
    always_comb begin
        w_hit[0] = (m_addr >= rom_base)   && (m_addr < rom_top);
        w_hit[1] = (m_addr >= uart_base)  && (m_addr < uart_top);
        w_hit[2] = (m_addr >= clint_base) && (m_addr < clint_top);
        w_hit[3] = (m_addr >= tim0_base)  && (m_addr < tim0_top);
        w_hit[4] = (m_addr >= tim1_base)  && (m_addr < tim1_top);
        w_hit[5] = (m_addr >= ram_base)   && (m_addr < ram_top);
        w_hitIdx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_hitIdx = 3'(i);
            end
        end
    end

    assign w_selReady = s_ready[r_sel];
    assign w_selData  = s_rdata[{r_sel, 5'd0} +: 32];

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
`ifdef BUS_TIMEOUT_EN
        w_timeout = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (m_valid) begin
                    w_accept = 1'b1;
                    w_next   = (|w_hit) ? S_REQ : S_RESP;
                end
            end
            S_REQ, S_WAIT: begin
                if (w_selReady) begin
                    w_capture = 1'b1;
                    w_next    = S_RESP;
                end
`ifdef BUS_TIMEOUT_EN
                else if (r_count == CNT_W'(timeout_cycles - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = S_RESP;
                end
`endif
                else begin
                    w_next = S_WAIT;
                end
            end
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sel   <= 3'd0;
            r_rdata <= 32'd0;
            r_error <= 1'b0;
            s_instr <= 1'b0;
            s_addr  <= 32'd0;
            s_wdata <= 32'd0;
            s_wstrb <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                s_instr <= m_instr;
                s_addr  <= m_addr;
                s_wdata <= m_wdata;
                s_wstrb <= m_wstrb;
                r_sel   <= w_hitIdx;
                r_error <= ~(|w_hit);
                r_rdata <= 32'd0;
            end
            if (w_capture) begin
                r_rdata <= w_selData;
            end
`ifdef BUS_TIMEOUT_EN
            if (w_timeout) begin
                r_error <= 1'b1;
            end
`endif
        end
    end

`ifdef BUS_TIMEOUT_EN
    // Cleared at acceptance so it reads zero during the REQ cycle.
    always_ff @(posedge clock) begin
        if (reset || w_accept) begin
            r_count <= '0;
        end else if (r_state == S_REQ || r_state == S_WAIT) begin
            r_count <= r_count + 1'b1;
        end
    end
`endif

    assign s_valid = (r_state == S_REQ) ? (6'd1 << r_sel) : 6'd0;
    assign m_ready = (r_state == S_RESP);
    assign m_error = (r_state == S_RESP) && r_error;
    assign m_rdata = (r_state == S_RESP) ? r_rdata : 32'd0;

endmodule

// File: tb/tb_bus_decoder.sv
// Randomized self-checking bench for bus_decoder against an address-map model.
// Define BUS_TIMEOUT_EN to also exercise the slave timeout path.
module tb_bus_decoder;

    logic         clock = 1'b0;
    logic         reset;
    logic         m_valid;
    logic         m_instr;
    logic [31:0]  m_addr;
    logic [31:0]  m_wdata;
    logic [3:0]   m_wstrb;
    logic [31:0]  m_rdata;
    logic         m_ready;
    logic         m_error;
    logic [5:0]   s_valid;
    logic         s_instr;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic [191:0] s_rdata;
    logic [5:0]   s_ready;

    int nChecks = 0;
    int nPass   = 0;

    logic [31:0] mapBase [6] = '{32'h0, 32'h1000000, 32'h2000000, 32'h10000000, 32'h20000000, 32'h80000000};
    logic [31:0] mapTop  [6] = '{32'h80, 32'h1000004, 32'h200C000, 32'h10100000, 32'h20100000, 32'h90000000};

`ifdef BUS_TIMEOUT_EN
    localparam int TIMEOUT = 16;
`else
    localparam int TIMEOUT = 1024;
`endif

    bus_decoder #(.timeout_cycles(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
        .m_ready(m_ready), .m_error(m_error), .s_valid(s_valid),
        .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ready(s_ready)
    );

    always #5 clock = ~clock;

    function automatic int refDecode(input logic [31:0] a);
        for (int i = 0; i < 6; i++) begin
            if (a >= mapBase[i] && a < mapTop[i]) return i;
        end
        return -1;
    endfunction

    // Issues one request (called #1 after a posedge with the DUT idle); the selected
    // slave answers at cycle k. Unselected slaves toggle noisy ready lines throughout.
    task automatic doTxn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic instr, input int k,
                         input logic [31:0] rdata);
        int exp;
        logic [5:0] oneHot;
        exp = refDecode(addr);
        oneHot = (exp >= 0) ? (6'd1 << exp) : 6'd0;
        m_valid = 1'b1; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb; m_instr = instr;
        @(posedge clock); #1;
        m_valid = $urandom_range(0, 1); m_addr = $urandom; m_wdata = $urandom;
        if (exp < 0) begin
            @(negedge clock);
            nChecks++;
            if (m_ready !== 1'b1 || m_error !== 1'b1 || m_rdata !== 32'd0 || s_valid !== 6'd0)
                $display("[TB] FAIL %s unmapped resp: ready=%b err=%b rdata=%h sv=%b expected 1 1 0 0",
                         tag, m_ready, m_error, m_rdata, s_valid);
            else nPass++;
            nChecks++;
            if (s_addr !== addr || s_wdata !== wdata || s_wstrb !== wstrb || s_instr !== instr)
                $display("[TB] FAIL %s latch: addr=%h expected %h", tag, s_addr, addr);
            else nPass++;
            @(posedge clock); #1;
            m_valid = 1'b0;
            return;
        end
        for (int c = 1; c <= k; c++) begin
            for (int j = 0; j < 6; j++) s_rdata[j*32 +: 32] = $urandom;
            if (c == k) begin
                s_rdata[exp*32 +: 32] = rdata;
                s_ready = oneHot | (6'($urandom) & ~oneHot);
            end else begin
                s_ready = 6'($urandom) & ~oneHot;
            end
            @(negedge clock);
            nChecks++;
            if (s_valid !== ((c == 1) ? oneHot : 6'd0) || m_ready !== 1'b0)
                $display("[TB] FAIL %s cycle %0d: sv=%b ready=%b expected %b 0",
                         tag, c, s_valid, m_ready, (c == 1) ? oneHot : 6'd0);
            else nPass++;
            if (c == 1) begin
                nChecks++;
                if (s_addr !== addr || s_wdata !== wdata || s_wstrb !== wstrb || s_instr !== instr)
                    $display("[TB] FAIL %s latch: addr=%h wdata=%h wstrb=%h instr=%b expected %h %h %h %b",
                             tag, s_addr, s_wdata, s_wstrb, s_instr, addr, wdata, wstrb, instr);
                else nPass++;
            end
            @(posedge clock); #1;
            s_ready = 6'd0;
        end
        @(negedge clock);
        nChecks++;
        if (m_ready !== 1'b1 || m_error !== 1'b0 || m_rdata !== rdata)
            $display("[TB] FAIL %s resp: ready=%b err=%b rdata=%h expected 1 0 %h",
                     tag, m_ready, m_error, m_rdata, rdata);
        else nPass++;
        @(posedge clock); #1;
        m_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; m_valid = 1'b0; m_instr = 1'b0; m_addr = '0; m_wdata = '0;
        m_wstrb = '0; s_rdata = '0; s_ready = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        nChecks++;
        if (m_ready !== 1'b0 || m_error !== 1'b0 || m_rdata !== 32'd0 || s_valid !== 6'd0 ||
            s_addr !== 32'd0 || s_wdata !== 32'd0 || s_wstrb !== 4'd0 || s_instr !== 1'b0)
            $display("[TB] FAIL reset values: ready=%b err=%b rdata=%h sv=%b addr=%h expected all zero",
                     m_ready, m_error, m_rdata, s_valid, s_addr);
        else nPass++;
        @(posedge clock); #1;
    endtask

    task automatic test_directed();
        doTxn("rom_read", 32'h7C, 32'h0, 4'h0, 1'b1, 1, 32'hDEADBEEF);
        doTxn("uart_write", 32'h01000000, 32'h41, 4'h1, 1'b0, 4, 32'h12345678);
        doTxn("unmapped_80", 32'h80, 32'h0, 4'h0, 1'b0, 1, 32'h0);
        doTxn("unmapped_3000", 32'h30000000, 32'h0, 4'h0, 1'b0, 1, 32'h0);
        doTxn("ram_last", 32'h8FFFFFFC, 32'h0, 4'h0, 1'b0, 2, 32'hCAFEF00D);
        doTxn("unmapped_9000", 32'h90000000, 32'h0, 4'h0, 1'b0, 1, 32'h0);
    endtask

    task automatic test_boundaries();
        for (int i = 0; i < 6; i++) begin
            doTxn("win_base", mapBase[i], $urandom, 4'h0, 1'b0, 1, $urandom);
            doTxn("win_last", mapTop[i] - 32'd1, $urandom, 4'hF, 1'b0, 2, $urandom);
            doTxn("win_top", mapTop[i], $urandom, 4'h0, 1'b0, 1, 32'h0);
        end
    endtask

    task automatic test_ignore_other_ready();
        m_valid = 1'b1; m_addr = 32'h2000000; m_wstrb = 4'h0; m_instr = 1'b0; m_wdata = 32'h0;
        @(posedge clock); #1;
        m_valid = 1'b0;
        s_ready = 6'b100000;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            nChecks++;
            if (m_ready !== 1'b0)
                $display("[TB] FAIL foreign_ready cycle %0d: ready=%b expected 0", c, m_ready);
            else nPass++;
            @(posedge clock); #1;
        end
        s_ready = 6'b000100; s_rdata[64 +: 32] = 32'hC11A7000;
        @(posedge clock); #1;
        s_ready = 6'd0;
        @(negedge clock);
        nChecks++;
        if (m_ready !== 1'b1 || m_rdata !== 32'hC11A7000)
            $display("[TB] FAIL foreign_ready resp: ready=%b rdata=%h expected 1 c11a7000", m_ready, m_rdata);
        else nPass++;
        @(posedge clock); #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int w;
            logic [31:0] a;
            w = $urandom_range(0, 6);
            if (w == 6) a = $urandom;
            else a = mapBase[w] + $urandom_range(0, mapTop[w] - mapBase[w] - 1);
            doTxn("random", a, $urandom, 4'($urandom), 1'($urandom), $urandom_range(1, 5), $urandom);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 8; n++)
            doTxn("b2b", 32'h80000000 + 32'(n * 4), 32'h0, 4'h0, 1'b0, 1, 32'(n) * 32'h01010101);
    endtask

    task automatic test_reset_midflight();
        m_valid = 1'b1; m_addr = 32'h2000010; m_wdata = 32'h55; m_wstrb = 4'h3; m_instr = 1'b1;
        @(posedge clock); #1;
        m_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        s_ready = 6'b000100; s_rdata = {6{32'hBAD0BAD0}};
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            nChecks++;
            if (m_ready !== 1'b0 || m_error !== 1'b0 || m_rdata !== 32'd0 || s_valid !== 6'd0 ||
                s_addr !== 32'd0 || s_wdata !== 32'd0 || s_wstrb !== 4'd0 || s_instr !== 1'b0)
                $display("[TB] FAIL reset_midflight cycle %0d: ready=%b err=%b rdata=%h sv=%b addr=%h expected all zero",
                         c, m_ready, m_error, m_rdata, s_valid, s_addr);
            else nPass++;
            @(posedge clock); #1;
        end
        s_ready = 6'd0;
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        m_valid = 1'b1; m_addr = 32'h10000000; m_wstrb = 4'h0; m_instr = 1'b0; m_wdata = 32'h0;
        @(posedge clock); #1;
        m_valid = 1'b0;
        for (int c = 1; c <= TIMEOUT; c++) begin
            @(negedge clock);
            nChecks++;
            if (m_ready !== 1'b0)
                $display("[TB] FAIL timeout early cycle %0d: ready=%b expected 0", c, m_ready);
            else nPass++;
            @(posedge clock); #1;
        end
        @(negedge clock);
        nChecks++;
        if (m_ready !== 1'b1 || m_error !== 1'b1 || m_rdata !== 32'd0)
            $display("[TB] FAIL timeout resp: ready=%b err=%b rdata=%h expected 1 1 0", m_ready, m_error, m_rdata);
        else nPass++;
        @(posedge clock); #1;
        doTxn("after_timeout", 32'h10000100, 32'h0, 4'h0, 1'b0, 3, 32'h7117E0);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_boundaries();
        test_ignore_other_ready();
        test_random();
        test_back_to_back();
        test_reset_midflight();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`endif
        doTxn("final", 32'h7C, 32'h0, 4'h0, 1'b0, 1, 32'h600DF00D);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/bus_decoder.md
# bus_decoder

Single-master address decoder and transaction sequencer between the core's memory port and the SoC slaves (rom, uart, clint, tim0, tim1, ram). It decodes each request against the system address map and forwards it as a one-cycle strobe to exactly one slave. It then waits for that slave's ready and returns registered read data and ready to the master. Unmapped accesses complete with an error response.

## Interface
Parameters:
- rom_base / rom_top, default 32'h0 / 32'h80: rom window
- uart_base / uart_top, default 32'h1000000 / 32'h1000004: uart window
- clint_base / clint_top, default 32'h2000000 / 32'h200C000: clint window
- tim0_base / tim0_top, default 32'h10000000 / 32'h10100000: tim0 window
- tim1_base / tim1_top, default 32'h20000000 / 32'h20100000: tim1 window
- ram_base / ram_top, default 32'h80000000 / 32'h90000000: ram window
- timeout_cycles, default 1024: slave response limit (only with BUS_TIMEOUT_EN)

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- m_valid  in  1  request strobe from master
- m_instr  in  1  instruction-fetch flag
- m_addr  in  32  byte address
- m_wdata  in  32  write data
- m_wstrb  in  4  byte write enables; 0 = read
- m_rdata  out  32  response data
- m_ready  out  1  one-cycle completion pulse
- m_error  out  1  error flag, valid with m_ready
- s_valid  out  6  one-hot slave strobe; index 0 rom, 1 uart, 2 clint, 3 tim0, 4 tim1, 5 ram
- s_instr / s_addr / s_wdata / s_wstrb  out  1/32/32/4  latched request, shared by all slaves
- s_rdata  in  192  packed slave read data; slave i at bits [32i+31:32i]
- s_ready  in  6  per-slave completion

## Operation
- State machine with states IDLE, REQ, WAIT and RESP.
- IDLE: on m_valid, latch instr/addr/wdata/wstrb and decode.
  - A slave matches when base <= addr < top (unsigned; top is exclusive).
  - If windows overlap, the lowest index wins.
  - Match: go to REQ with sel set to the matching index.
  - No match: go to RESP with error=1 and rdata=0.
- REQ: drive s_valid[sel]=1 for this cycle only.
  - If s_ready[sel] is high in the same cycle, capture s_rdata slice sel and go to RESP.
  - Otherwise go to WAIT.
- WAIT: s_valid=0. When s_ready[sel] is high, capture the slice and go to RESP.
- RESP: m_ready=1 and m_rdata=captured data for one cycle, then go to IDLE.
- Write responses return whatever rdata the slave drives.
- s_ready of unselected slaves is ignored in every state. Any s_ready seen in IDLE is ignored.
- m_valid outside IDLE is ignored. The master issues no new request until m_ready.
- s_addr carries the full address, not a window offset.
- s_instr/s_addr/s_wdata/s_wstrb hold their latched values from REQ until the next accepted request.

## Timing
- Reset values: state IDLE; m_ready 0, m_error 0, m_rdata 0; s_valid 0; s_addr, s_wdata, s_wstrb, s_instr 0; sel 0.
- Mapped request accepted at cycle 0:
  - s_valid at cycle 1.
  - Slave ready at cycle k>=1 gives m_ready at cycle k+1. Minimum latency is 2 cycles.
- Unmapped request at cycle 0: m_ready=1, m_error=1, m_rdata=0 at cycle 1.
- A request can be accepted in the cycle after RESP. Sustained throughput is one transaction per 3 cycles.
- Reset asserted in any state:
  - Next cycle is IDLE with all outputs at reset values.
  - A pending transaction is dropped with no m_ready.

## Configuration
- BUS_TIMEOUT_EN defined:
  - A counter (width $clog2(timeout_cycles+1)) clears on entry to REQ and increments each cycle in REQ/WAIT.
  - If it reaches timeout_cycles without s_ready[sel], go to RESP with m_error=1 and m_rdata=0.
  - A ready arriving in the same cycle as the timeout wins, giving a normal response.
- BUS_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely. The timeout_cycles parameter is unused.

## Test plan
- Read 0x0000007C, rom ready at cycle 1 with rdata 0xDEADBEEF -> s_valid=6'b000001 at cycle 1; m_ready=1, m_rdata=0xDEADBEEF, m_error=0 at cycle 2.
- Write 0x01000000, wdata 0x41, wstrb 4'h1, uart ready after 3 cycles -> s_valid=6'b000010 at cycle 1 only; s_wdata=0x41; m_ready at cycle 5.
- Read 0x00000080 and read 0x30000000 -> both give m_ready=1, m_error=1, m_rdata=0 at cycle 1; s_valid stays 0.
- Read 0x8FFFFFFC -> goes to ram (index 5). Read 0x90000000 -> error. s_ready[5] pulsed while clint is selected -> ignored, no m_ready.
- BUS_TIMEOUT_EN with timeout_cycles=16, tim0 never ready -> m_ready=1, m_error=1 after 16 REQ/WAIT cycles; the next request is accepted normally.
- Reset asserted in WAIT, then stale s_ready asserted in IDLE -> no m_ready; all outputs at reset values.
